// File: rtl/rr_bus_arbiter8_if.sv
// Bus bundle between eight requesters, the shared sink and rr_bus_arbiter8.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_bus_arbiter8_if #(
    parameter int WIDTH = 32
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] in_data;
    logic               out_ready;
`ifdef ARB_LOCK_EN
    logic               lock;
`endif
    logic [7:0]         gnt;
    logic [2:0]         sel;
    logic [7:0]         ack;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;

    modport master (
        input  req, in_data, out_ready,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        output gnt, sel, ack, out_valid, out_data
    );

    modport slave (
        output req, in_data, out_ready,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        input  gnt, sel, ack, out_valid, out_data
    );
endinterface

// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter/sequencer for eight sources onto one valid/ready port,
// bursts bounded to MAX_BURST beats. Define ARB_LOCK_EN to let a source extend its grant.
module rr_bus_arbiter8 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    rr_bus_arbiter8_if.master bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    logic [0:0] state_p0;
    logic [7:0] gnt_p0;
    logic [2:0] sel_p0;
    logic [2:0] last_p0;
    logic [3:0] beat_cnt_p0;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;
    logic       transfer;
    logic       at_limit;
    logic       lock_hold;
    logic       release_grant;

`ifdef ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Search starts just after the last winner so every source gets its turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_p0 + 3'(k);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign bus.out_valid = (state_p0 == GRANT) && bus.req[sel_p0] && !reset;
    assign transfer      = bus.out_valid && bus.out_ready;
    assign at_limit      = (beat_cnt_p0 == LAST_BEAT);
    assign release_grant = !bus.req[sel_p0] || (transfer && at_limit && !lock_hold);

    assign bus.ack      = transfer ? (8'b1 << sel_p0) : 8'b0;
    assign bus.out_data = reset ? bus.in_data[0 +: WIDTH]
                                : bus.in_data[sel_p0*WIDTH +: WIDTH];
    assign bus.gnt      = gnt_p0;
    assign bus.sel      = sel_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0    <= IDLE;
            gnt_p0      <= '0;
            sel_p0      <= '0;
            last_p0     <= 3'd7;
            beat_cnt_p0 <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (found) begin
                        state_p0    <= GRANT;
                        gnt_p0      <= 8'b1 << winner;
                        sel_p0      <= winner;
                        last_p0     <= winner;
                        beat_cnt_p0 <= '0;
                    end else begin
                        gnt_p0 <= '0;
                    end
                end
                default: begin
                    if (release_grant) begin
                        state_p0    <= IDLE;
                        gnt_p0      <= '0;
                        beat_cnt_p0 <= '0;
                    end else if (transfer && !at_limit) begin
                        // A locked burst parks the counter at the last beat.
                        beat_cnt_p0 <= beat_cnt_p0 + 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Directed bench for rr_bus_arbiter8 (WIDTH=32, MAX_BURST=4).
// Lock scenario is compiled in when ARB_LOCK_EN is defined.
module tb_rr_bus_arbiter8;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ack3   = 0;

    rr_bus_arbiter8_if #(.WIDTH(W)) bus ();

    rr_bus_arbiter8 #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One transferring beat from source s: check, then advance a cycle.
    task automatic beat(input string tag, input int s);
        settle();
        chk({tag, "_gnt"},  bus.gnt, 32'(8'b1 << s));
        chk({tag, "_sel"},  bus.sel, 32'(s));
        chk({tag, "_ack"},  bus.ack, 32'(8'b1 << s));
        chk({tag, "_data"}, bus.out_data, word(s));
        step();
    endtask

    task automatic bubble(input string tag);
        settle();
        chk({tag, "_bub_gnt"}, bus.gnt, 32'h0);
        chk({tag, "_bub_ack"}, bus.ack, 32'h0);
        step();
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
        bus.lock      = 1'b0;
`endif
        for (int i = 0; i < 8; i++) bus.in_data[i*W +: W] = word(i);
        step();

        // Reset values and idle with no requests
        settle();
        chk("rst_gnt",  bus.gnt, 32'h0);
        chk("rst_sel",  bus.sel, 32'h0);
        chk("rst_vld",  32'(bus.out_valid), 32'h0);
        chk("rst_data", bus.out_data, word(0));
        reset = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("idle_gnt", bus.gnt, 32'h0);
            chk("idle_vld", 32'(bus.out_valid), 32'h0);
            chk("idle_ack", bus.ack, 32'h0);
            step();
        end

        // Single requester: 4 beats, bubble, regrant
        bus.req = 8'h01; bus.out_ready = 1'b1;
        settle();
        chk("t2_pre_gnt", bus.gnt, 32'h0);
        step();
        for (int b = 0; b < 4; b++) beat("t2", 0);
        bubble("t2");
        settle();
        chk("t2_regrant", bus.gnt, 32'h01);
        bus.req = 8'h00;
        step();
        settle();
        chk("t2_drop_gnt", bus.gnt, 32'h0);

        // All requesting: order 0..7,0 with 4 beats each
        do_reset();
        bus.req = 8'hFF; bus.out_ready = 1'b1;
        bubble("t3_first");
        for (int g = 0; g < 9; g++) begin
            for (int b = 0; b < 4; b++) beat("t3", g % 8);
            bubble("t3");
        end

        // Sink stalls: grant held without acks, then drains, then src7
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'h84; bus.out_ready = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("t4_hold_gnt", bus.gnt, 32'h04);
            chk("t4_hold_vld", 32'(bus.out_valid), 32'h1);
            chk("t4_hold_ack", bus.ack, 32'h0);
            step();
        end
        bus.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) beat("t4", 2);
        bubble("t4");
        settle();
        chk("t4_next_gnt", bus.gnt, 32'h80);

        // Source 3 withdraws after 2 beats, source 5 wins next
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'h28;
        step();
        for (int b = 0; b < 2; b++) begin
            settle();
            if (bus.ack[3]) ack3++;
            beat("t5", 3);
        end
        bus.req = 8'h20;
        settle();
        chk("t5_drop_ack", bus.ack, 32'h0);
        chk("t5_drop_gnt", bus.gnt, 32'h08);
        step();
        bubble("t5");
        settle();
        chk("t5_next_gnt", bus.gnt, 32'h20);
        chk("t5_ack3_cnt", 32'(ack3), 32'd2);

        // Reset during beat 2 of a grant
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'hFF;
        step();
        beat("t6", 0);
        beat("t6", 0);
        reset = 1'b1;
        settle();
        chk("t6_rst_ack", bus.ack, 32'h0);
        chk("t6_rst_vld", 32'(bus.out_valid), 32'h0);
        step();
        settle();
        chk("t6_rst_gnt", bus.gnt, 32'h0);
        reset = 1'b0;
        step();
        settle();
        chk("t6_after_gnt", bus.gnt, 32'h01);

`ifdef ARB_LOCK_EN
        // Locked burst on source 2 beyond the limit, then release
        bus.req = 8'h00;
        do_reset();
        bus.req = 8'h06; bus.lock = 1'b0;
        step();
        for (int b = 0; b < 4; b++) beat("lk_src1", 1);
        bubble("lk");
        bus.lock = 1'b1;
        for (int b = 0; b < 10; b++) beat("lk_src2", 2);
        bus.lock = 1'b0;
        beat("lk_last", 2);
        bubble("lk_rel");
        settle();
        chk("lk_next_gnt", bus.gnt, 32'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
